// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - PC/IR owner and FETCH..WRITE stage sequencer; optional perf counters via FETCH_PERF_EN
module fetch_seq #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        mem_busy,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [2:0]  state,
  output logic [31:0] instr_raw,
  output logic [31:0] pc,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;

  // State, PC and instruction register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  // Next-state logic: each input is only looked at in the stage that owns it.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          w_instr_nxt = imem_rdata;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = S_MEM;
      S_MEM: begin
        if (!mem_busy) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // Redirect targets are forced word-aligned; sequential step wraps mod 2^32.
        w_pc_nxt    = branch_taken ? {branch_target[31:2], 2'b00} : r_pc + 32'd4;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign imem_req  = (r_state == S_FETCH) && !rst;
  assign imem_addr = r_pc;
  assign state     = r_state;
  assign instr_raw = r_instr;
  assign pc        = r_pc;

`ifdef FETCH_PERF_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  // Free-running cycle count and retired-instruction count, one retire per WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= 64'd0;
      r_instret_cnt <= 64'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (r_state == S_WRITE) begin
        r_instret_cnt <= r_instret_cnt + 64'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - self-checking bench for fetch_seq
module tb_fetch_seq;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic        mem_busy = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [2:0]  state;
  logic [31:0] instr_raw;
  logic [31:0] pc;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  fetch_seq #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .mem_busy(mem_busy),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .state(state), .instr_raw(instr_raw), .pc(pc),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_k     = 0;

  // Reference model: architectural PC, IR contents and event counts.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  longint unsigned m_cyc;
  longint unsigned m_ret;

  typedef struct {
    int          w;
    int          b;
    bit          br;
    logic [31:0] tgt;
    logic [31:0] word;
    bit          exec_br;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, m_k, act, exp);
    end
  endtask

  task automatic check_counters();
`ifdef FETCH_PERF_EN
    check("cycle_cnt", cycle_cnt, 64'(m_cyc));
    check("instret_cnt", instret_cnt, 64'(m_ret));
`else
    check("cycle_cnt", cycle_cnt, 64'd0);
    check("instret_cnt", instret_cnt, 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    m_k = -1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr_raw, NOP_INSTR);
    m_pc    = RESET_PC;
    m_instr = NOP_INSTR;
    m_cyc   = 0;
    m_ret   = 0;
    check_counters();
    rst = 1'b0;
  endtask

  // One instruction: w FETCH wait cycles, b mem_busy cycles. Ignored inputs get noise.
  task automatic run_instr(input int w, input int b, input bit br, input logic [31:0] tgt,
                           input logic [31:0] word, input bit exec_br, input int abort_at);
    int total;
    logic [2:0] exp_st;
    total = w + b + 5;
    for (int k = 0; k < total; k++) begin
      #1;
      m_k = k;
      if (k <= w)               exp_st = 3'd0;
      else if (k == w + 1)      exp_st = 3'd1;
      else if (k == w + 2)      exp_st = 3'd2;
      else if (k <= w + 3 + b)  exp_st = 3'd3;
      else                      exp_st = 3'd4;
      check("state", state, exp_st);
      check("imem_req", imem_req, (k <= w) ? 1'b1 : 1'b0);
      check("imem_addr", imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("instr_raw", instr_raw, (k <= w) ? m_instr : word);
      check_counters();
      if (k == abort_at) return;
      imem_ready = (exp_st == 3'd0) ? (k == w) : 1'($urandom_range(0, 1));
      imem_rdata = (k == w) ? word : $urandom;
      mem_busy   = (exp_st == 3'd3) ? (k < w + 3 + b) : 1'($urandom_range(0, 1));
      if (exp_st == 3'd4) begin
        branch_taken  = br;
        branch_target = tgt;
      end else if (exp_st == 3'd2 && exec_br) begin
        branch_taken  = 1'b1;
        branch_target = 32'h0000_1002;
      end else begin
        branch_taken  = 1'($urandom_range(0, 1));
        branch_target = $urandom;
      end
      m_cyc++;
      @(negedge clk);
    end
    m_pc    = br ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    m_instr = word;
    m_ret++;
  endtask

  initial begin
    vecs[0] = '{w: 0, b: 0, br: 0, tgt: 32'h0,         word: 32'h0010_0093, exec_br: 0, exp_pc: 32'h0000_0004};
    vecs[1] = '{w: 3, b: 0, br: 0, tgt: 32'h0,         word: 32'h00A0_0093, exec_br: 0, exp_pc: 32'h0000_0008};
    vecs[2] = '{w: 0, b: 2, br: 0, tgt: 32'h0,         word: 32'h0020_8133, exec_br: 0, exp_pc: 32'h0000_000C};
    vecs[3] = '{w: 0, b: 0, br: 1, tgt: 32'h0000_1002, word: 32'h0000_0063, exec_br: 0, exp_pc: 32'h0000_1000};
    vecs[4] = '{w: 0, b: 0, br: 0, tgt: 32'h0000_1002, word: 32'h0000_0013, exec_br: 1, exp_pc: 32'h0000_1004};
    vecs[5] = '{w: 1, b: 1, br: 1, tgt: 32'hFFFF_FFFF, word: 32'h0000_006F, exec_br: 0, exp_pc: 32'hFFFF_FFFC};
    vecs[6] = '{w: 0, b: 0, br: 0, tgt: 32'h0,         word: 32'h0000_0013, exec_br: 0, exp_pc: 32'h0000_0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      run_instr(vecs[i].w, vecs[i].b, vecs[i].br, vecs[i].tgt, vecs[i].word, vecs[i].exec_br, -1);
      #1;
      check("vec_next_pc", imem_addr, vecs[i].exp_pc);
    end

    // Reset arrives in the second MEM cycle of a stalled instruction.
    run_instr(0, 3, 1, 32'h0000_4000, 32'h0040_0113, 0, 4);
    do_reset();
    run_instr(0, 0, 0, 32'h0, 32'h0050_0193, 0, -1);
    #1;
    check("post_rst_pc", pc, 32'h0000_0004);
`ifdef FETCH_PERF_EN
    check("post_rst_instret", instret_cnt, 64'd1);
`else
    check("post_rst_instret", instret_cnt, 64'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, 1'($urandom_range(0, 1)), -1);
    end
    #1;
    check("final_pc", pc, m_pc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch and stage-sequencing block for the multicycle core. It owns the program counter, fetches each instruction from instruction memory over a ready handshake, and holds it in the instruction register. It drives the 3-bit `state` that every downstream stage (decode, ALU, memory, writeback) keys on. On the last cycle of each instruction it commits the next PC from the branch outcome.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, instruction-register value after reset (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_rdata`  in  32  fetched word; valid only when `imem_ready`=1.
- `imem_ready`  in  1  memory accepts the request and returns data in the same cycle.
- `mem_busy`  in  1  data memory / IO not finished; holds MEM.
- `branch_taken`  in  1  redirect request; sampled in WRITE.
- `branch_target`  in  32  redirect address; sampled in WRITE.
- `state`  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WRITE.
- `instr_raw`  out  32  instruction register.
- `pc`  out  32  address of the instruction in `instr_raw`.
- `cycle_cnt`  out  64  cycles since reset (see Configuration).
- `instret_cnt`  out  64  instructions completed (see Configuration).

## Operation
- Reset values: `state`=0, `pc`=`RESET_PC`, `instr_raw`=`NOP_INSTR`, counters=0. `imem_req`=0 whenever `rst`=1.
- `imem_req` = (`state`==FETCH) && !`rst`. It is combinational. `imem_addr`=`pc`.
- FETCH: hold `imem_req` and `imem_addr` stable until `imem_ready`. On the ready cycle: `instr_raw`<=`imem_rdata`, `state`<=DECODE. No ready means stay in FETCH indefinitely, with `instr_raw` unchanged.
- DECODE -> EXEC -> MEM, one cycle each, unconditional.
- MEM: stay while `mem_busy`=1; go to WRITE on the first cycle with `mem_busy`=0.
- WRITE: one cycle, then FETCH. On this cycle:
  - `pc` <= `branch_taken` ? {`branch_target`[31:2],2'b00} : `pc`+4.
  - Addition wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Illegal state encodings 5-7 go to FETCH on the next cycle. `pc` is unchanged.
- `branch_taken`/`branch_target` are ignored outside WRITE.
- `mem_busy` is ignored outside MEM.
- `imem_ready` is ignored outside FETCH.
- Reset mid-instruction: in-flight instruction is abandoned, with no PC commit and no counter increment. The next cycle is FETCH at `RESET_PC`.

## Timing
- `pc` and `instr_raw` are stable from DECODE through WRITE. Downstream stages latch the decoded fields in DECODE.
- Minimum instruction latency is 5 cycles, reached when `imem_ready` comes in the first FETCH cycle and `mem_busy`=0. Each FETCH wait cycle or `mem_busy` cycle adds one.
- New `pc` is visible on `imem_addr` in the first FETCH cycle after WRITE.
- All outputs except `imem_req`/`imem_addr` are registered. `imem_addr` is driven directly from the `pc` register.

## Configuration
- `FETCH_PERF_EN` defined:
  - `cycle_cnt` increments every non-reset cycle.
  - `instret_cnt` increments on each WRITE cycle.
  - Both are 64-bit, wrap to 0, and clear on reset.
- `FETCH_PERF_EN` undefined: counter registers are not built; `cycle_cnt` and `instret_cnt` are tied to 0.

## Test plan
- Reset, `imem_ready`=1 always, `mem_busy`=0, no branch:
  - First `imem_addr`=0x0.
  - `state` sequence 0,1,2,3,4,0.
  - Second fetch at 0x4, 5 cycles after the first.
- FETCH with `imem_ready` low 3 cycles, `imem_rdata`=0x00A00093 on the ready cycle:
  - `imem_req` held 4 cycles at a constant address.
  - `instr_raw`=0x00A00093 in DECODE.
- `mem_busy` high 2 cycles in MEM: MEM lasts 3 cycles, and the instruction takes 7 cycles total.
- `branch_taken`=1, `branch_target`=0x0000_1002 in WRITE: next `imem_addr`=0x0000_1000. The same inputs pulsed in EXEC only give `pc`+4.
- `pc`=0xFFFF_FFFC, no branch: next fetch at 0x0.
- `rst` asserted in MEM:
  - Next cycle has `state`=0, `pc`=`RESET_PC` and `instr_raw`=0x00000013.
  - With `FETCH_PERF_EN`, `instret_cnt`=0 and increments to 1 after the first completed instruction.
